// File: rtl/vx_csr_rsp_gather_pkg.sv
// rtl/vx_csr_rsp_gather_pkg.sv - shared widths and gather FSM state encoding
package vx_csr_rsp_gather_pkg;

    localparam int UUID_WIDTH    = 44;
    localparam int NW_WIDTH      = 2;
    localparam int PC_BITS       = 30;
    localparam int NUM_REGS_BITS = 5;

    // Exposed so perf/debug tooling can decode the gather state.
    typedef enum logic [1:0] {
        CSR_IDLE   = 2'd0,
        CSR_GATHER = 2'd1,
        CSR_FULL   = 2'd2
    } csr_gather_state_t;

endpackage

// File: rtl/vx_csr_rsp_gather.sv
// rtl/vx_csr_rsp_gather.sv - gathers NUM_LANES-wide CSR response beats into one warp record
module vx_csr_rsp_gather
    import vx_csr_rsp_gather_pkg::*;
#(
    parameter int  NUM_LANES   = 4,
    parameter int  NUM_THREADS = 16,
    parameter int  XLEN        = 32,
    localparam int PID_BITS    = $clog2(NUM_THREADS / NUM_LANES),
    localparam int PID_WIDTH   = (PID_BITS > 0) ? PID_BITS : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UUID_WIDTH-1:0]       in_uuid,
    input  logic [NW_WIDTH-1:0]         in_wid,
    input  logic [NUM_LANES-1:0]        in_tmask,
    input  logic [PC_BITS-1:0]          in_PC,
    input  logic [NUM_REGS_BITS-1:0]    in_rd,
    input  logic                        in_wb,
    input  logic [NUM_LANES*XLEN-1:0]   in_data,
    input  logic [PID_WIDTH-1:0]        in_pid,
    input  logic                        in_sop,
    input  logic                        in_eop,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UUID_WIDTH-1:0]       out_uuid,
    output logic [NW_WIDTH-1:0]         out_wid,
    output logic [PC_BITS-1:0]          out_PC,
    output logic [NUM_REGS_BITS-1:0]    out_rd,
    output logic                        out_wb,
    output logic [NUM_THREADS-1:0]      out_tmask,
    output logic [NUM_THREADS*XLEN-1:0] out_data,
    output logic                        proto_err
);

    localparam int NUM_PKTS = NUM_THREADS / NUM_LANES;

    csr_gather_state_t          r_state;
    logic                       r_out_valid;
    logic                       r_err;
    logic [UUID_WIDTH-1:0]      r_uuid;
    logic [NW_WIDTH-1:0]        r_wid;
    logic [PC_BITS-1:0]         r_pc;
    logic [NUM_REGS_BITS-1:0]   r_rd;
    logic                       r_wb;
    logic [NUM_PKTS-1:0]        r_seen;
    logic [NUM_LANES*XLEN-1:0]  r_pkt_data [NUM_PKTS];
    logic [NUM_LANES-1:0]       r_pkt_mask [NUM_PKTS];

    logic                       w_fire;
    logic                       w_sop_fire;
    logic                       w_wr;
    logic                       w_dup;
    logic                       w_hdr_mismatch;
    logic [NUM_PKTS-1:0]        w_pid_oh;
    logic [NUM_LANES*XLEN-1:0]  w_beat_data;

    assign in_ready       = (r_state != CSR_FULL) || out_ready;
    assign w_fire         = in_valid && in_ready;
    assign w_sop_fire     = w_fire && in_sop;
    // Non-sop beats only land while a record is open; in IDLE/FULL they are dropped.
    assign w_wr           = w_fire && (in_sop || (r_state == CSR_GATHER));
    assign w_dup          = |(r_seen & w_pid_oh);
    assign w_hdr_mismatch = (in_wid != r_wid) || (in_uuid != r_uuid);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign w_beat_data[l*XLEN +: XLEN] = in_tmask[l] ? in_data[l*XLEN +: XLEN] : '0;
    end

    for (genvar p = 0; p < NUM_PKTS; p++) begin : g_pkt
        if (NUM_PKTS == 1) begin : g_one
            logic w_unused_pid;
            assign w_unused_pid = ^in_pid;
            assign w_pid_oh[p]  = 1'b1;
        end else begin : g_many
            assign w_pid_oh[p] = (in_pid == PID_WIDTH'(p));
        end

        // A beat for this slot wins over the sop clear, so a sop beat lands in a clean buffer.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_pkt_data[p] <= '0;
                r_pkt_mask[p] <= '0;
            end else if (w_wr && w_pid_oh[p]) begin
                r_pkt_data[p] <= w_beat_data;
                r_pkt_mask[p] <= in_tmask;
            end else if (w_sop_fire) begin
                r_pkt_data[p] <= '0;
                r_pkt_mask[p] <= '0;
            end
        end

        assign out_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] = r_pkt_data[p];
        assign out_tmask[p*NUM_LANES +: NUM_LANES]          = r_pkt_mask[p];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= CSR_IDLE;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_uuid      <= '0;
            r_wid       <= '0;
            r_pc        <= '0;
            r_rd        <= '0;
            r_wb        <= 1'b0;
            r_seen      <= '0;
        end else if (w_sop_fire) begin
            r_uuid      <= in_uuid;
            r_wid       <= in_wid;
            r_pc        <= in_PC;
            r_rd        <= in_rd;
            r_wb        <= in_wb;
            r_seen      <= w_pid_oh;
            r_state     <= in_eop ? CSR_FULL : CSR_GATHER;
            r_out_valid <= in_eop;
            if (r_state == CSR_GATHER) begin
                r_err <= 1'b1;
            end
        end else if (w_fire && (r_state == CSR_GATHER)) begin
            r_seen <= r_seen | w_pid_oh;
            if (w_dup || w_hdr_mismatch) begin
                r_err <= 1'b1;
            end
            if (in_eop) begin
                r_state     <= CSR_FULL;
                r_out_valid <= 1'b1;
            end
        end else begin
            if (w_fire) begin
                r_err <= 1'b1;
            end
            if ((r_state == CSR_FULL) && out_ready) begin
                r_state     <= CSR_IDLE;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_uuid  = r_uuid;
    assign out_wid   = r_wid;
    assign out_PC    = r_pc;
    assign out_rd    = r_rd;
    assign out_wb    = r_wb;
    assign proto_err = r_err;

endmodule

// File: tb/tb_vx_csr_rsp_gather.sv
// tb/tb_vx_csr_rsp_gather.sv - randomized bench for vx_csr_rsp_gather against a thread-array model
module tb_vx_csr_rsp_gather;
    import vx_csr_rsp_gather_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // 4-lane instance
    logic                     a_in_valid, a_in_ready, a_wb, a_sop, a_eop;
    logic [UUID_WIDTH-1:0]    a_uuid;
    logic [NW_WIDTH-1:0]      a_wid;
    logic [3:0]               a_tmask;
    logic [PC_BITS-1:0]       a_pc;
    logic [NUM_REGS_BITS-1:0] a_rd;
    logic [127:0]             a_data;
    logic [1:0]               a_pid;
    logic                     a_out_valid, a_out_ready, a_o_wb, a_err;
    logic [UUID_WIDTH-1:0]    a_o_uuid;
    logic [NW_WIDTH-1:0]      a_o_wid;
    logic [PC_BITS-1:0]       a_o_pc;
    logic [NUM_REGS_BITS-1:0] a_o_rd;
    logic [15:0]              a_o_tmask;
    logic [511:0]             a_o_data;

    // 16-lane instance
    logic                     b_in_valid, b_in_ready, b_wb, b_sop, b_eop, b_pid;
    logic [UUID_WIDTH-1:0]    b_uuid;
    logic [NW_WIDTH-1:0]      b_wid;
    logic [15:0]              b_tmask;
    logic [PC_BITS-1:0]       b_pc;
    logic [NUM_REGS_BITS-1:0] b_rd;
    logic [511:0]             b_data;
    logic                     b_out_valid, b_out_ready, b_o_wb, b_err;
    logic [UUID_WIDTH-1:0]    b_o_uuid;
    logic [NW_WIDTH-1:0]      b_o_wid;
    logic [PC_BITS-1:0]       b_o_pc;
    logic [NUM_REGS_BITS-1:0] b_o_rd;
    logic [15:0]              b_o_tmask;
    logic [511:0]             b_o_data;

    vx_csr_rsp_gather #(.NUM_LANES(4), .NUM_THREADS(16), .XLEN(32)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_uuid(a_uuid), .in_wid(a_wid),
        .in_tmask(a_tmask), .in_PC(a_pc), .in_rd(a_rd), .in_wb(a_wb), .in_data(a_data),
        .in_pid(a_pid), .in_sop(a_sop), .in_eop(a_eop),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_uuid(a_o_uuid), .out_wid(a_o_wid),
        .out_PC(a_o_pc), .out_rd(a_o_rd), .out_wb(a_o_wb), .out_tmask(a_o_tmask),
        .out_data(a_o_data), .proto_err(a_err)
    );

    vx_csr_rsp_gather #(.NUM_LANES(16), .NUM_THREADS(16), .XLEN(32)) u_dut16 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_uuid(b_uuid), .in_wid(b_wid),
        .in_tmask(b_tmask), .in_PC(b_pc), .in_rd(b_rd), .in_wb(b_wb), .in_data(b_data),
        .in_pid(b_pid), .in_sop(b_sop), .in_eop(b_eop),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_uuid(b_o_uuid), .out_wid(b_o_wid),
        .out_PC(b_o_pc), .out_rd(b_o_rd), .out_wb(b_o_wb), .out_tmask(b_o_tmask),
        .out_data(b_o_data), .proto_err(b_err)
    );

    // Reference model: per-thread arrays for the record being collected and the record on offer
    bit                       m_gather, m_full, m_err;
    bit [3:0]                 m_seen;
    logic [31:0]              m_col_d [16];
    bit                       m_col_m [16];
    logic [31:0]              m_out_d [16];
    bit                       m_out_m [16];
    logic [UUID_WIDTH-1:0]    m_h_uuid, m_o_uuid;
    logic [NW_WIDTH-1:0]      m_h_wid,  m_o_wid;
    logic [PC_BITS-1:0]       m_h_pc,   m_o_pc;
    logic [NUM_REGS_BITS-1:0] m_h_rd,   m_o_rd;
    bit                       m_h_wb,   m_o_wb;

    task automatic chk_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_gather = 0; m_full = 0; m_err = 0; m_seen = '0;
        for (int t = 0; t < 16; t++) begin
            m_col_d[t] = '0; m_col_m[t] = 0; m_out_d[t] = '0; m_out_m[t] = 0;
        end
    endtask

    task automatic model_a(input bit rdy);
        int t;
        if (m_full && a_out_ready) m_full = 0;
        if (a_in_valid && rdy) begin
            if (a_sop) begin
                if (m_gather) m_err = 1;
                for (int i = 0; i < 16; i++) begin m_col_d[i] = '0; m_col_m[i] = 0; end
                m_seen = '0; m_gather = 1;
                m_h_uuid = a_uuid; m_h_wid = a_wid; m_h_pc = a_pc; m_h_rd = a_rd; m_h_wb = a_wb;
            end else if (m_gather) begin
                if (a_wid != m_h_wid || a_uuid != m_h_uuid) m_err = 1;
                if (m_seen[a_pid]) m_err = 1;
            end else begin
                m_err = 1;
            end
            if (m_gather) begin
                for (int k = 0; k < 4; k++) begin
                    t = int'(a_pid) * 4 + k;
                    m_col_m[t] = a_tmask[k];
                    m_col_d[t] = a_tmask[k] ? a_data[k*32 +: 32] : 32'h0;
                end
                m_seen[a_pid] = 1;
                if (a_eop) begin
                    for (int i = 0; i < 16; i++) begin m_out_d[i] = m_col_d[i]; m_out_m[i] = m_col_m[i]; end
                    m_o_uuid = m_h_uuid; m_o_wid = m_h_wid; m_o_pc = m_h_pc; m_o_rd = m_h_rd; m_o_wb = m_h_wb;
                    m_full = 1; m_gather = 0;
                end
            end
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick_a();
        logic [511:0] ed;
        logic [15:0]  em;
        bit           rdy;
        #1;
        rdy = !m_full || a_out_ready;
        chk_val("a_in_ready", 512'(a_in_ready), 512'(rdy));
        chk_val("a_out_valid", 512'(a_out_valid), 512'(m_full));
        chk_val("a_proto_err", 512'(a_err), 512'(m_err));
        if (m_full) begin
            for (int t = 0; t < 16; t++) begin ed[t*32 +: 32] = m_out_d[t]; em[t] = m_out_m[t]; end
            chk_val("a_out_data", a_o_data, ed);
            chk_val("a_out_tmask", 512'(a_o_tmask), 512'(em));
            chk_val("a_out_uuid", 512'(a_o_uuid), 512'(m_o_uuid));
            chk_val("a_out_wid", 512'(a_o_wid), 512'(m_o_wid));
            chk_val("a_out_PC", 512'(a_o_pc), 512'(m_o_pc));
            chk_val("a_out_rd", 512'(a_o_rd), 512'(m_o_rd));
            chk_val("a_out_wb", 512'(a_o_wb), 512'(m_o_wb));
        end
        model_a(rdy);
        @(negedge clk);
    endtask

    task automatic send_a(input int pid, input bit sop, input bit eop, input logic [3:0] tm,
                          input logic [127:0] d);
        a_in_valid = 1'b1; a_pid = 2'(pid); a_sop = sop; a_eop = eop; a_tmask = tm; a_data = d;
        tick_a();
        a_in_valid = 1'b0;
    endtask

    task automatic new_hdr_a();
        a_uuid = UUID_WIDTH'({$urandom, $urandom});
        a_wid  = NW_WIDTH'($urandom);
        a_pc   = PC_BITS'($urandom);
        a_rd   = NUM_REGS_BITS'($urandom);
        a_wb   = 1'($urandom);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        #1;
        chk_val("rst_out_valid", 512'(a_out_valid), 512'(1'b0));
        chk_val("rst_proto_err", 512'(a_err), 512'(1'b0));
        chk_val("rst_in_ready", 512'(a_in_ready), 512'(1'b1));
        chk_val("rst_out_data", a_o_data, 512'(0));
        chk_val("rst_out_tmask", 512'(a_o_tmask), 512'(0));
        chk_val("rst_out_uuid", 512'(a_o_uuid), 512'(0));
        chk_val("rst_b_out_valid", 512'(b_out_valid), 512'(1'b0));
        chk_val("rst_b_proto_err", 512'(b_err), 512'(1'b0));
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0]          d;
        logic [127:0]          pd;
        logic [511:0]          ed;
        logic [UUID_WIDTH-1:0] h2_uuid;
        logic [511:0]          bd [3];
        logic [15:0]           bm [3];
        logic [UUID_WIDTH-1:0] bu [3];
        int                    g_len, g_idx;
        bit                    junk, vld, exp_rdy;
        logic [NW_WIDTH-1:0]   g_wid;

        a_in_valid = 0; a_out_ready = 1; a_sop = 0; a_eop = 0; a_pid = '0; a_tmask = '0; a_data = '0;
        a_uuid = '0; a_wid = '0; a_pc = '0; a_rd = '0; a_wb = 0;
        b_in_valid = 0; b_out_ready = 1; b_sop = 0; b_eop = 0; b_pid = 0; b_tmask = '0; b_data = '0;
        b_uuid = '0; b_wid = '0; b_pc = '0; b_rd = '0; b_wb = 0;
        do_reset();

        // Full 4-beat gather with lane pattern 0x100*pid+k
        new_hdr_a();
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'h100 * p + k;
            send_a(p, p == 0, p == 3, 4'hF, d);
        end
        #1;
        for (int t = 0; t < 16; t++) ed[t*32 +: 32] = 32'h100 * (t / 4) + (t % 4);
        chk_val("t1_valid_lat1", 512'(a_out_valid), 512'(1'b1));
        chk_val("t1_data_pattern", a_o_data, ed);
        chk_val("t1_tmask_full", 512'(a_o_tmask), 512'(16'hFFFF));
        tick_a();
        tick_a();

        // Backpressure: record held 5 cycles while the next sop waits
        a_out_ready = 0;
        new_hdr_a();
        for (int p = 0; p < 4; p++) send_a(p, p == 0, p == 3, 4'hF, rand128());
        new_hdr_a();
        a_in_valid = 1; a_pid = 0; a_sop = 1; a_eop = 0; a_tmask = 4'hF; a_data = rand128();
        for (int c = 0; c < 5; c++) tick_a();
        a_out_ready = 1;
        tick_a();
        a_in_valid = 0;
        for (int p = 1; p < 4; p++) send_a(p, 0, p == 3, 4'hF, rand128());
        tick_a();
        tick_a();

        // Partial mask: only lanes 0 and 2 of pid1 survive
        new_hdr_a();
        pd = rand128() | {4{32'h1}};
        send_a(0, 1, 0, 4'h0, rand128());
        send_a(1, 0, 0, 4'b0101, pd);
        send_a(2, 0, 0, 4'h0, rand128());
        send_a(3, 0, 1, 4'h0, rand128());
        #1;
        ed = '0;
        ed[4*32 +: 32] = pd[31:0];
        ed[6*32 +: 32] = pd[95:64];
        chk_val("t3_tmask", 512'(a_o_tmask), 512'(16'h0050));
        chk_val("t3_data", a_o_data, ed);
        tick_a();
        tick_a();

        // Protocol errors: stray beat in IDLE, then a restarted record
        new_hdr_a();
        send_a(2, 0, 0, 4'hF, rand128());
        #1;
        chk_val("t5_err_set", 512'(a_err), 512'(1'b1));
        send_a(0, 1, 0, 4'hF, rand128());
        send_a(1, 0, 0, 4'hF, rand128());
        new_hdr_a();
        h2_uuid = a_uuid;
        for (int p = 0; p < 4; p++) send_a(p, p == 0, p == 3, 4'hF, rand128());
        #1;
        chk_val("t5_second_uuid", 512'(a_o_uuid), 512'(h2_uuid));
        chk_val("t5_err_sticky", 512'(a_err), 512'(1'b1));
        tick_a();
        tick_a();

        // Asynchronous reset mid-gather, then orphan beats
        new_hdr_a();
        send_a(0, 1, 0, 4'hF, rand128());
        send_a(1, 0, 0, 4'hF, rand128());
        do_reset();
        send_a(2, 0, 0, 4'hF, rand128());
        send_a(3, 0, 1, 4'hF, rand128());
        tick_a();
        #1;
        chk_val("t6_no_output", 512'(a_out_valid), 512'(1'b0));
        chk_val("t6_err_after", 512'(a_err), 512'(1'b1));
        tick_a();

        // Randomized traffic with occasional protocol violations
        do_reset();
        g_len = 0; g_idx = 0; g_wid = '0;
        for (int c = 0; c < 600; c++) begin
            if (g_idx == g_len) begin
                g_len = $urandom_range(4, 1); g_idx = 0;
                new_hdr_a(); g_wid = a_wid;
            end
            a_out_ready = ($urandom_range(3) != 0);
            vld  = ($urandom_range(3) != 0);
            junk = ($urandom_range(15) == 0);
            a_in_valid = vld; a_tmask = 4'($urandom); a_data = rand128();
            if (junk) begin
                a_sop = 1'($urandom); a_eop = 1'($urandom); a_pid = 2'($urandom);
                a_wid = NW_WIDTH'($urandom);
            end else begin
                a_sop = (g_idx == 0); a_eop = (g_idx == g_len - 1); a_pid = 2'(g_idx);
                a_wid = g_wid;
            end
            exp_rdy = !m_full || a_out_ready;
            tick_a();
            if (vld && exp_rdy && !junk) g_idx++;
        end
        a_in_valid = 0; a_out_ready = 1;
        tick_a();
        tick_a();

        // 16-lane instance: three back-to-back single-beat records
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bd[i] = {4{rand128()}};
            bm[i] = 16'($urandom);
            bu[i] = UUID_WIDTH'({$urandom, $urandom});
        end
        b_out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                b_in_valid = 1; b_sop = 1; b_eop = 1; b_pid = 0;
                b_data = bd[i]; b_tmask = bm[i]; b_uuid = bu[i];
            end else begin
                b_in_valid = 0;
            end
            #1;
            chk_val("b_in_ready", 512'(b_in_ready), 512'(1'b1));
            chk_val("b_out_valid", 512'(b_out_valid), 512'(i > 0));
            chk_val("b_proto_err", 512'(b_err), 512'(1'b0));
            if (i > 0) begin
                for (int t = 0; t < 16; t++)
                    ed[t*32 +: 32] = bm[i-1][t] ? bd[i-1][t*32 +: 32] : 32'h0;
                chk_val("b_out_data", b_o_data, ed);
                chk_val("b_out_tmask", 512'(b_o_tmask), 512'(bm[i-1]));
                chk_val("b_out_uuid", 512'(b_o_uuid), 512'(bu[i-1]));
            end
            @(negedge clk);
        end
        #1;
        chk_val("b_drained", 512'(b_out_valid), 512'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
